// File: rtl/dmem_responder_if.sv
// Request/response bus between the MIPS memory stage and the data-memory responder.
interface dmem_responder_if;
    logic        memreq;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        done;
    logic        misalign;

    modport master (
        output memreq, memwrite, addr, writedata,
        input  readdata, stall, done, misalign
    );

    modport slave (
        input  memreq, memwrite, addr, writedata,
        output readdata, stall, done, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with programmable wait states and a pipeline stall output.
// Optional macro DMEM_READ_BYPASS_EN lets loads skip the wait states.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

`ifdef DMEM_READ_BYPASS_EN
    localparam bit ReadBypass = 1'b1;
`else
    localparam bit ReadBypass = 1'b0;
`endif

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;

    logic [31:0]   mem [DEPTH];

    logic          access;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_write;
    logic          acc_mis;
    logic [AW-1:0] acc_idx;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            StIdle: begin
                if (bus.memreq) begin
                    addr_d  = bus.addr[AW+1:0];
                    wdata_d = bus.writedata;
                    write_d = bus.memwrite;
                    cnt_d   = WaitInit;
                    if (WAIT_STATES == 0 || (ReadBypass && !bus.memwrite)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The array is touched on the edge entering DONE; from IDLE the latches are not loaded yet.
    assign access    = reset && (state_d == StDone) && (state_q != StDone);
    assign acc_addr  = (state_q == StIdle) ? bus.addr[AW+1:0] : addr_q;
    assign acc_wdata = (state_q == StIdle) ? bus.writedata    : wdata_q;
    assign acc_write = (state_q == StIdle) ? bus.memwrite     : write_q;
    assign acc_mis   = (acc_addr[1:0] != 2'b00);
    assign acc_idx   = acc_addr[AW+1:2];

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (access) begin
            mis_d = acc_mis;
            if (acc_mis) begin
                rdata_d = 32'd0;
            end else if (!acc_write) begin
                rdata_d = mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (access && acc_write && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.done     = (state_q == StDone);
    assign bus.misalign = (state_q == StDone) && mis_q;
    assign bus.stall    = ((state_q == StIdle) && bus.memreq) || (state_q == StWait);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core's memory stage.
- Receives word load/store requests (address = aluoutM, data = writedata, memwriteM) and returns readdata.
- Models a word-addressed RAM with a configurable number of wait states.
- Drives a stall output so the pipeline holds the memory stage until the access completes.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two; ADDR_W = log2(DEPTH).
- WAIT_STATES, 2, extra cycles between acceptance and completion; range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memreq  input  1  access request; held high by the requester until done pulses.
- memwrite  input  1  1 = store, 0 = load; sampled with memreq.
- addr  input  32  byte address.
- writedata  input  32  store data.
- readdata  output  32  load data; valid in the done cycle.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle completion pulse.
- misalign  output  1  error flag; pulses with done when addr[1:0] != 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - readdata = 0, done = 0, misalign = 0, wait counter = 0.
  - Any pending request is dropped, and a pending store is not performed.
  - RAM contents are not reset.
- Word index = addr[ADDR_W+1:2]. Addresses beyond DEPTH wrap modulo DEPTH.
- FSM states: IDLE, WAIT, DONE.
  - IDLE with memreq = 1:
    - Latch addr, writedata and memwrite.
    - Counter := WAIT_STATES.
    - Next state = WAIT if WAIT_STATES > 0, else DONE.
  - WAIT:
    - Counter decrements each cycle.
    - On the cycle the counter reaches 1, the next state = DONE.
  - Array access happens on the WAIT->DONE or IDLE->DONE transition edge:
    - Store writes the latched data.
    - Load registers the array word into readdata.
  - DONE:
    - done = 1 for this cycle only.
    - Next state is always IDLE. memreq is ignored in DONE.
- stall = (state == IDLE and memreq) or (state == WAIT). stall is 0 in DONE so the pipeline advances at the end of the DONE cycle.
- Latency: done is asserted WAIT_STATES+1 cycles after the acceptance edge.
- A request occupies WAIT_STATES+2 cycles, including the acceptance cycle.
- Back-to-back requests: the next request is seen in IDLE on the cycle after DONE. There are no dead cycles beyond that.
- readdata holds its last value until the next load completes. Stores do not change readdata.
- Misaligned access (latched addr[1:0] != 0):
  - No array write.
  - readdata := 0.
  - misalign = 1 in the DONE cycle.
  - Timing is identical to an aligned access.
- Requester changing addr, writedata or memwrite while stalled has no effect; the latched copies are used.
- Reset asserted in any state takes the block immediately to IDLE, with outputs as in reset.

Optional Feature:
- Macro: DMEM_READ_BYPASS_EN.
- Defined:
  - Loads skip WAIT: IDLE with a load request goes directly to DONE (done one cycle after acceptance).
  - Stores still take WAIT_STATES.
  - misalign rules are unchanged.
- Undefined: loads and stores both use WAIT_STATES as described above.

Test Plan:
- Reset: hold reset = 0 with memreq = 1 -> readdata = 0, done = 0, stall = 1 (combinational from IDLE+memreq); after reset release, the FSM accepts on the first edge.
- WAIT_STATES = 2, store addr = 0x0000_0010, data = 0xDEAD_BEEF, then load the same addr:
  - Store: stall high for 3 cycles, done pulses on the 4th cycle.
  - Load: readdata = 0xDEADBEEF with done on the 4th cycle of the load.
- Wrap: DEPTH = 64, store 0x1234_5678 to addr 0x0000_0100, load addr 0x0000_0000 -> readdata = 0x12345678.
- Misaligned store to addr 0x0000_0022, data 0xFFFF_FFFF:
  - misalign = 1 with done.
  - A subsequent load of 0x0000_0020 returns the prior contents (unchanged).
- Reset mid-operation: assert reset during WAIT of a store to 0x0000_0008 with data 0xAAAA_5555 -> a later load of 0x0000_0008 returns the old value, and done never pulses for the aborted access.
- Back-to-back and bypass:
  - WAIT_STATES = 0, two consecutive loads: each completes in 2 cycles with no idle gap.
  - With DMEM_READ_BYPASS_EN defined and WAIT_STATES = 3: a load's done comes 1 cycle after acceptance, while a store's done comes 4 cycles after acceptance.
